// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg
//    Shared definitions for the memory-access stage: the controller state
//    encoding, the default timeout limit and the wait-counter width.
//    Imported by mem_stage and mem_stage_ctrl.
package mem_stage_pkg;

   // Controller states. ERR is terminal until reset.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      ERR  = 2'd2
   } memStateT;

   // BUSY cycles without mem_done before the stage gives up (legal range 1..255).
   localparam int DEFAULT_MAX_WAIT = 15;

   // The wait counter is sized for the largest legal MAX_WAIT.
   localparam int WAIT_CNT_W = 8;

endpackage

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl
//    Control half of the memory stage: IDLE/BUSY/ERR state machine, the
//    BUSY wait counter, the kill flag for flushed in-flight accesses, and
//    the stall / mem_req / err / outValid outputs. It also hands the
//    datapath one-cycle strobes saying when to latch inputs or results.
// Ports
//    clk, rst    clock, synchronous active-high reset
//    inValid     EX presents an instruction
//    flush       kill the in-flight or incoming instruction
//    memOp       instruction is a load or store
//    illegalOp   unaligned address or load+store together
//    memDone     memory completes this cycle
//    stall       EX must hold its inputs
//    memReq      registered memory request, held until memDone
//    err         sticky error flag
//    outValid    registered one-cycle write-back valid pulse
//    acceptAlu   latch a non-memory instruction straight into the WB bundle
//    acceptMem   latch a memory instruction into the pending registers
//    retire      copy the pending instruction into the WB bundle
import mem_stage_pkg::*;

module mem_stage_ctrl #(
   parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
   input  logic clk,
   input  logic rst,
   input  logic inValid,
   input  logic flush,
   input  logic memOp,
   input  logic illegalOp,
   input  logic memDone,
   output logic stall,
   output logic memReq,
   output logic err,
   output logic outValid,
   output logic acceptAlu,
   output logic acceptMem,
   output logic retire
);

   memStateT              state;
   logic [WAIT_CNT_W-1:0] waitCnt;
   logic                  kill;
   logic                  takeInput;

   // An instruction is taken only in IDLE and only if it is not being flushed.
   // A flush arriving in the same cycle as mem_done also kills the result.
   always_comb begin
      takeInput = (state == IDLE) && inValid && !flush;
      acceptAlu = takeInput && !memOp;
      acceptMem = takeInput && memOp && !illegalOp;
      retire    = (state == BUSY) && memDone && !kill && !flush;
      stall     = (state != IDLE) || (takeInput && memOp);
   end

   // State machine with registered request, error and valid outputs. The
   // wait counter counts BUSY cycles without mem_done; the last permitted
   // cycle moves to ERR and drops the request.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         waitCnt  <= '0;
         kill     <= 1'b0;
         err      <= 1'b0;
         memReq   <= 1'b0;
         outValid <= 1'b0;
      end else begin
         outValid <= 1'b0;
         case (state)
            IDLE: begin
               if (takeInput) begin
                  if (!memOp) begin
                     outValid <= 1'b1;
                  end else if (illegalOp) begin
                     err   <= 1'b1;
                     state <= ERR;
                  end else begin
                     state   <= BUSY;
                     memReq  <= 1'b1;
                     waitCnt <= '0;
                     kill    <= 1'b0;
                  end
               end
            end
            BUSY: begin
               if (memDone) begin
                  state    <= IDLE;
                  memReq   <= 1'b0;
                  kill     <= 1'b0;
                  outValid <= !(kill || flush);
               end else begin
                  if (flush) begin
                     kill <= 1'b1;
                  end
                  waitCnt <= waitCnt + 1'b1;
                  if (waitCnt == WAIT_CNT_W'(MAX_WAIT - 1)) begin
                     err    <= 1'b1;
                     memReq <= 1'b0;
                     state  <= ERR;
                  end
               end
            end
            ERR: begin
               state <= ERR;
            end
            default: begin
               state  <= IDLE;
               memReq <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/mem_stage.sv
// mem_stage
//    Memory-access stage between execute and write-back. Non-memory
//    instructions pass through with one cycle of latency; loads and stores
//    are issued to a variable-latency data memory over a req/done handshake
//    while EX is stalled. The registered WB bundle is updated only when a
//    result is delivered, so its data fields hold while out_valid is low.
// Ports
//    clk, rst                         clock, synchronous active-high reset
//    in_valid, flush                  EX handshake and kill
//    aluResult, storeData, nextPC     EX data (aluResult is the memory address)
//    memRead, memWrite                load / store select
//    memToReg, writeR7, writeEn       WB control passed through
//    writeReg                         destination register
//    stall                            EX must hold its inputs
//    mem_req, mem_wr, mem_addr,
//    mem_wdata, mem_done, mem_rdata   data-memory handshake
//    out_valid, out_*                 WB bundle
//    err                              sticky error
import mem_stage_pkg::*;

module mem_stage #(
   parameter int DATA_W   = 16,
   parameter int REG_W    = 3,
   parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic              flush,
   input  logic [DATA_W-1:0] aluResult,
   input  logic [DATA_W-1:0] storeData,
   input  logic [DATA_W-1:0] nextPC,
   input  logic              memRead,
   input  logic              memWrite,
   input  logic              memToReg,
   input  logic              writeR7,
   input  logic              writeEn,
   input  logic [REG_W-1:0]  writeReg,
   output logic              stall,
   output logic              mem_req,
   output logic              mem_wr,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_done,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_readData,
   output logic [DATA_W-1:0] out_aluResult,
   output logic [DATA_W-1:0] out_nextPC,
   output logic              out_memToReg,
   output logic              out_writeR7,
   output logic              out_writeEn,
   output logic [REG_W-1:0]  out_writeReg,
   output logic              err
);

   logic              memOp;
   logic              illegalOp;
   logic              acceptAlu;
   logic              acceptMem;
   logic              retire;
   logic [DATA_W-1:0] pendNextPC;
   logic              pendMemToReg;
   logic              pendWriteR7;
   logic              pendWriteEn;
   logic [REG_W-1:0]  pendWriteReg;
   logic              bundleWriteEn;

   // Halfword accesses must be even; a load and store at once is undefined.
   always_comb begin
      memOp     = memRead || memWrite;
      illegalOp = aluResult[0] || (memRead && memWrite);
   end

   mem_stage_ctrl #(
      .MAX_WAIT(MAX_WAIT)
   ) ctrl (
      .clk      (clk),
      .rst      (rst),
      .inValid  (in_valid),
      .flush    (flush),
      .memOp    (memOp),
      .illegalOp(illegalOp),
      .memDone  (mem_done),
      .stall    (stall),
      .memReq   (mem_req),
      .err      (err),
      .outValid (out_valid),
      .acceptAlu(acceptAlu),
      .acceptMem(acceptMem),
      .retire   (retire)
   );

   // Pending registers hold an accepted memory instruction for the whole
   // access; address, write data and direction drive the memory port
   // directly so they stay stable while mem_req is high.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_addr     <= '0;
         mem_wdata    <= '0;
         mem_wr       <= 1'b0;
         pendNextPC   <= '0;
         pendMemToReg <= 1'b0;
         pendWriteR7  <= 1'b0;
         pendWriteEn  <= 1'b0;
         pendWriteReg <= '0;
      end else if (acceptMem) begin
         mem_addr     <= aluResult;
         mem_wdata    <= storeData;
         mem_wr       <= memWrite;
         pendNextPC   <= nextPC;
         pendMemToReg <= memToReg;
         pendWriteR7  <= writeR7;
         pendWriteEn  <= writeEn;
         pendWriteReg <= writeReg;
      end
   end

   // The WB bundle is loaded either straight from EX (non-memory op) or from
   // the pending registers when the access retires. Stores leave readData
   // untouched since nothing downstream consumes it.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_readData  <= '0;
         out_aluResult <= '0;
         out_nextPC    <= '0;
         out_memToReg  <= 1'b0;
         out_writeR7   <= 1'b0;
         bundleWriteEn <= 1'b0;
         out_writeReg  <= '0;
      end else if (acceptAlu) begin
         out_aluResult <= aluResult;
         out_nextPC    <= nextPC;
         out_memToReg  <= memToReg;
         out_writeR7   <= writeR7;
         bundleWriteEn <= writeEn;
         out_writeReg  <= writeReg;
      end else if (retire) begin
         if (!mem_wr) begin
            out_readData <= mem_rdata;
         end
         out_aluResult <= mem_addr;
         out_nextPC    <= pendNextPC;
         out_memToReg  <= pendMemToReg;
         out_writeR7   <= pendWriteR7;
         bundleWriteEn <= pendWriteEn;
         out_writeReg  <= pendWriteReg;
      end
   end

   // Register writes must only happen on the cycle the bundle is valid.
   always_comb begin
      out_writeEn = bundleWriteEn && out_valid;
   end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage
//    Directed self-checking bench for mem_stage. Each task drives one
//    scenario and compares outputs against hand-computed values. Inputs
//    change 1 ns after the rising edge; outputs are sampled before the next.
module tb_mem_stage;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        flush;
   logic [15:0] aluResult;
   logic [15:0] storeData;
   logic [15:0] nextPC;
   logic        memRead;
   logic        memWrite;
   logic        memToReg;
   logic        writeR7;
   logic        writeEn;
   logic [2:0]  writeReg;
   logic        stall;
   logic        mem_req;
   logic        mem_wr;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_done;
   logic [15:0] mem_rdata;
   logic        out_valid;
   logic [15:0] out_readData;
   logic [15:0] out_aluResult;
   logic [15:0] out_nextPC;
   logic        out_memToReg;
   logic        out_writeR7;
   logic        out_writeEn;
   logic [2:0]  out_writeReg;
   logic        err;

   int checks;
   int failures;

   mem_stage dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .flush        (flush),
      .aluResult    (aluResult),
      .storeData    (storeData),
      .nextPC       (nextPC),
      .memRead      (memRead),
      .memWrite     (memWrite),
      .memToReg     (memToReg),
      .writeR7      (writeR7),
      .writeEn      (writeEn),
      .writeReg     (writeReg),
      .stall        (stall),
      .mem_req      (mem_req),
      .mem_wr       (mem_wr),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_done     (mem_done),
      .mem_rdata    (mem_rdata),
      .out_valid    (out_valid),
      .out_readData (out_readData),
      .out_aluResult(out_aluResult),
      .out_nextPC   (out_nextPC),
      .out_memToReg (out_memToReg),
      .out_writeR7  (out_writeR7),
      .out_writeEn  (out_writeEn),
      .out_writeReg (out_writeReg),
      .err          (err)
   );

   // 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case a scenario wedges.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clearInputs();
      in_valid  = 1'b0;
      flush     = 1'b0;
      aluResult = '0;
      storeData = '0;
      nextPC    = '0;
      memRead   = 1'b0;
      memWrite  = 1'b0;
      memToReg  = 1'b0;
      writeR7   = 1'b0;
      writeEn   = 1'b0;
      writeReg  = '0;
      mem_done  = 1'b0;
      mem_rdata = '0;
   endtask

   task automatic applyReset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   // Every output must read zero right after reset with idle inputs.
   task automatic checkAllZero(input string tag);
      checks++; if (stall !== 1'b0) begin failures++; $display("[TB] FAIL %s stall got=%b exp=0", tag, stall); end
      checks++; if (mem_req !== 1'b0) begin failures++; $display("[TB] FAIL %s mem_req got=%b exp=0", tag, mem_req); end
      checks++; if (mem_wr !== 1'b0) begin failures++; $display("[TB] FAIL %s mem_wr got=%b exp=0", tag, mem_wr); end
      checks++; if (mem_addr !== 16'h0) begin failures++; $display("[TB] FAIL %s mem_addr got=%h exp=0", tag, mem_addr); end
      checks++; if (mem_wdata !== 16'h0) begin failures++; $display("[TB] FAIL %s mem_wdata got=%h exp=0", tag, mem_wdata); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL %s out_valid got=%b exp=0", tag, out_valid); end
      checks++; if (out_readData !== 16'h0) begin failures++; $display("[TB] FAIL %s out_readData got=%h exp=0", tag, out_readData); end
      checks++; if (out_aluResult !== 16'h0) begin failures++; $display("[TB] FAIL %s out_aluResult got=%h exp=0", tag, out_aluResult); end
      checks++; if (out_nextPC !== 16'h0) begin failures++; $display("[TB] FAIL %s out_nextPC got=%h exp=0", tag, out_nextPC); end
      checks++; if ({out_memToReg, out_writeR7, out_writeEn} !== 3'b000) begin failures++; $display("[TB] FAIL %s out_ctrl got=%b exp=000", tag, {out_memToReg, out_writeR7, out_writeEn}); end
      checks++; if (out_writeReg !== 3'd0) begin failures++; $display("[TB] FAIL %s out_writeReg got=%0d exp=0", tag, out_writeReg); end
      checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL %s err got=%b exp=0", tag, err); end
   endtask

   task automatic test_reset();
      clearInputs();
      rst = 1'b1;
      step();
      step();
      checkAllZero("reset");
      rst = 1'b0;
      step();
   endtask

   task automatic test_alu();
      in_valid  = 1'b1;
      aluResult = 16'h1234;
      nextPC    = 16'h0102;
      writeEn   = 1'b1;
      writeR7   = 1'b1;
      writeReg  = 3'd3;
      #1;
      checks++; if (stall !== 1'b0) begin failures++; $display("[TB] FAIL alu_stall got=%b exp=0", stall); end
      step();
      clearInputs();
      checks++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL alu_valid got=%b exp=1", out_valid); end
      checks++; if (out_aluResult !== 16'h1234) begin failures++; $display("[TB] FAIL alu_result got=%h exp=1234", out_aluResult); end
      checks++; if (out_writeReg !== 3'd3) begin failures++; $display("[TB] FAIL alu_writeReg got=%0d exp=3", out_writeReg); end
      checks++; if (out_nextPC !== 16'h0102) begin failures++; $display("[TB] FAIL alu_nextPC got=%h exp=0102", out_nextPC); end
      checks++; if (out_writeEn !== 1'b1) begin failures++; $display("[TB] FAIL alu_writeEn got=%b exp=1", out_writeEn); end
      checks++; if (out_writeR7 !== 1'b1) begin failures++; $display("[TB] FAIL alu_writeR7 got=%b exp=1", out_writeR7); end
      checks++; if (mem_req !== 1'b0) begin failures++; $display("[TB] FAIL alu_memreq got=%b exp=0", mem_req); end
      step();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL alu_pulse got=%b exp=0", out_valid); end
      checks++; if (out_writeEn !== 1'b0) begin failures++; $display("[TB] FAIL alu_writeEnGate got=%b exp=0", out_writeEn); end
      checks++; if (out_aluResult !== 16'h1234) begin failures++; $display("[TB] FAIL alu_hold got=%h exp=1234", out_aluResult); end
   endtask

   task automatic test_load_latency();
      int stallCycles;
      stallCycles = 0;
      in_valid  = 1'b1;
      memRead   = 1'b1;
      memToReg  = 1'b1;
      writeEn   = 1'b1;
      writeReg  = 3'd4;
      aluResult = 16'h0040;
      #1;
      if (stall === 1'b1) stallCycles++;
      step();
      clearInputs();
      checks++; if (mem_req !== 1'b1) begin failures++; $display("[TB] FAIL load_req got=%b exp=1", mem_req); end
      checks++; if (mem_addr !== 16'h0040) begin failures++; $display("[TB] FAIL load_addr got=%h exp=0040", mem_addr); end
      checks++; if (mem_wr !== 1'b0) begin failures++; $display("[TB] FAIL load_wr got=%b exp=0", mem_wr); end
      if (stall === 1'b1) stallCycles++;
      step();
      if (stall === 1'b1) stallCycles++;
      step();
      mem_done  = 1'b1;
      mem_rdata = 16'hBEEF;
      #1;
      if (stall === 1'b1) stallCycles++;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL load_early got=%b exp=0", out_valid); end
      step();
      mem_done  = 1'b0;
      mem_rdata = 16'h0;
      #1;
      if (stall === 1'b1) stallCycles++;
      checks++; if (stallCycles !== 4) begin failures++; $display("[TB] FAIL load_stallCycles got=%0d exp=4", stallCycles); end
      checks++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL load_valid got=%b exp=1", out_valid); end
      checks++; if (out_readData !== 16'hBEEF) begin failures++; $display("[TB] FAIL load_data got=%h exp=BEEF", out_readData); end
      checks++; if (out_writeReg !== 3'd4) begin failures++; $display("[TB] FAIL load_writeReg got=%0d exp=4", out_writeReg); end
      checks++; if (mem_req !== 1'b0) begin failures++; $display("[TB] FAIL load_reqDrop got=%b exp=0", mem_req); end
      step();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL load_pulse got=%b exp=0", out_valid); end
   endtask

   task automatic test_back_to_back_fast_load();
      in_valid  = 1'b1;
      memRead   = 1'b1;
      aluResult = 16'h0042;
      step();
      clearInputs();
      mem_done  = 1'b1;
      mem_rdata = 16'h1357;
      #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL fast_early got=%b exp=0", out_valid); end
      step();
      clearInputs();
      checks++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL fast_valid got=%b exp=1", out_valid); end
      checks++; if (out_readData !== 16'h1357) begin failures++; $display("[TB] FAIL fast_data got=%h exp=1357", out_readData); end
      checks++; if (out_aluResult !== 16'h0042) begin failures++; $display("[TB] FAIL fast_addr got=%h exp=0042", out_aluResult); end
      step();
   endtask

   task automatic test_store();
      in_valid  = 1'b1;
      memWrite  = 1'b1;
      aluResult = 16'h0010;
      storeData = 16'h00AA;
      step();
      clearInputs();
      for (int c = 0; c < 2; c++) begin
         checks++; if (mem_req !== 1'b1) begin failures++; $display("[TB] FAIL store_req%0d got=%b exp=1", c, mem_req); end
         checks++; if (mem_wr !== 1'b1) begin failures++; $display("[TB] FAIL store_wr%0d got=%b exp=1", c, mem_wr); end
         checks++; if (mem_wdata !== 16'h00AA) begin failures++; $display("[TB] FAIL store_wdata%0d got=%h exp=00AA", c, mem_wdata); end
         checks++; if (mem_addr !== 16'h0010) begin failures++; $display("[TB] FAIL store_addr%0d got=%h exp=0010", c, mem_addr); end
         if (c == 1) mem_done = 1'b1;
         step();
      end
      mem_done = 1'b0;
      checks++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL store_valid got=%b exp=1", out_valid); end
      checks++; if (out_writeEn !== 1'b0) begin failures++; $display("[TB] FAIL store_writeEn got=%b exp=0", out_writeEn); end
      checks++; if (out_aluResult !== 16'h0010) begin failures++; $display("[TB] FAIL store_result got=%h exp=0010", out_aluResult); end
      checks++; if (mem_req !== 1'b0) begin failures++; $display("[TB] FAIL store_reqDrop got=%b exp=0", mem_req); end
      step();
   endtask

   task automatic test_flush_busy();
      in_valid  = 1'b1;
      memRead   = 1'b1;
      aluResult = 16'h0080;
      step();
      clearInputs();
      flush = 1'b1;
      step();
      flush = 1'b0;
      checks++; if (mem_req !== 1'b1) begin failures++; $display("[TB] FAIL flush_reqHeld got=%b exp=1", mem_req); end
      mem_done  = 1'b1;
      mem_rdata = 16'hDEAD;
      step();
      clearInputs();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL flush_noValid got=%b exp=0", out_valid); end
      checks++; if (stall !== 1'b0) begin failures++; $display("[TB] FAIL flush_idle got=%b exp=0", stall); end
      in_valid  = 1'b1;
      aluResult = 16'h5555;
      writeReg  = 3'd5;
      step();
      clearInputs();
      checks++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL flush_next got=%b exp=1", out_valid); end
      checks++; if (out_aluResult !== 16'h5555) begin failures++; $display("[TB] FAIL flush_nextData got=%h exp=5555", out_aluResult); end
      checks++; if (out_readData !== 16'h1357) begin failures++; $display("[TB] FAIL flush_readKept got=%h exp=1357", out_readData); end
      step();
   endtask

   task automatic test_flush_idle();
      in_valid  = 1'b1;
      flush     = 1'b1;
      memRead   = 1'b1;
      aluResult = 16'hAAAA;
      #1;
      checks++; if (stall !== 1'b0) begin failures++; $display("[TB] FAIL flushIdle_stall got=%b exp=0", stall); end
      step();
      clearInputs();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL flushIdle_valid got=%b exp=0", out_valid); end
      checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL flushIdle_err got=%b exp=0", err); end
      checks++; if (mem_req !== 1'b0) begin failures++; $display("[TB] FAIL flushIdle_req got=%b exp=0", mem_req); end
      step();
   endtask

   task automatic test_reset_busy();
      in_valid  = 1'b1;
      memRead   = 1'b1;
      aluResult = 16'h0060;
      step();
      clearInputs();
      checks++; if (mem_req !== 1'b1) begin failures++; $display("[TB] FAIL rstBusy_req got=%b exp=1", mem_req); end
      applyReset();
      checks++; if (mem_req !== 1'b0) begin failures++; $display("[TB] FAIL rstBusy_reqDrop got=%b exp=0", mem_req); end
      mem_done  = 1'b1;
      mem_rdata = 16'h9999;
      step();
      clearInputs();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL rstBusy_lateDone got=%b exp=0", out_valid); end
      checks++; if (out_readData !== 16'h0) begin failures++; $display("[TB] FAIL rstBusy_data got=%h exp=0", out_readData); end
      checks++; if (stall !== 1'b0) begin failures++; $display("[TB] FAIL rstBusy_stall got=%b exp=0", stall); end
   endtask

   task automatic test_unaligned();
      int reqSeen;
      reqSeen   = 0;
      in_valid  = 1'b1;
      memRead   = 1'b1;
      aluResult = 16'h0041;
      step();
      clearInputs();
      for (int c = 0; c < 5; c++) begin
         if (mem_req === 1'b1) reqSeen++;
         checks++; if ({stall, err} !== 2'b11) begin failures++; $display("[TB] FAIL unaligned_c%0d stall/err got=%b exp=11", c, {stall, err}); end
         in_valid = (c == 2);
         step();
      end
      clearInputs();
      checks++; if (reqSeen !== 0) begin failures++; $display("[TB] FAIL unaligned_req got=%0d exp=0", reqSeen); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL unaligned_valid got=%b exp=0", out_valid); end
      applyReset();
      checks++; if ({stall, err} !== 2'b00) begin failures++; $display("[TB] FAIL unaligned_rst got=%b exp=00", {stall, err}); end
   endtask

   task automatic test_illegal();
      in_valid  = 1'b1;
      memRead   = 1'b1;
      memWrite  = 1'b1;
      aluResult = 16'h0020;
      step();
      clearInputs();
      checks++; if (err !== 1'b1) begin failures++; $display("[TB] FAIL illegal_err got=%b exp=1", err); end
      checks++; if (mem_req !== 1'b0) begin failures++; $display("[TB] FAIL illegal_req got=%b exp=0", mem_req); end
      checks++; if (stall !== 1'b1) begin failures++; $display("[TB] FAIL illegal_stall got=%b exp=1", stall); end
      applyReset();
   endtask

   task automatic test_timeout();
      int busyCycles;
      busyCycles = 0;
      in_valid  = 1'b1;
      memRead   = 1'b1;
      aluResult = 16'h0030;
      step();
      clearInputs();
      for (int c = 0; c < 40; c++) begin
         if (err === 1'b1) break;
         if (mem_req === 1'b1) busyCycles++;
         step();
      end
      checks++; if (busyCycles !== 15) begin failures++; $display("[TB] FAIL timeout_cycles got=%0d exp=15", busyCycles); end
      checks++; if (err !== 1'b1) begin failures++; $display("[TB] FAIL timeout_err got=%b exp=1", err); end
      checks++; if (mem_req !== 1'b0) begin failures++; $display("[TB] FAIL timeout_req got=%b exp=0", mem_req); end
      checks++; if (stall !== 1'b1) begin failures++; $display("[TB] FAIL timeout_stall got=%b exp=1", stall); end
      applyReset();
      checkAllZero("timeoutRst");
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      clearInputs();
      test_reset();
      test_alu();
      test_load_latency();
      test_back_to_back_fast_load();
      test_store();
      test_flush_busy();
      test_flush_idle();
      test_reset_busy();
      test_unaligned();
      test_illegal();
      test_timeout();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
